mem_seq: RTL
============

Name: mem_seq

Overview:
- Memory-side sequencer behind the 4-port round-robin requester arbiter.
- Converts the arbiter's single shared req/wr/rdy transaction into single-port synchronous SRAM cycles with a fixed, parameterised read latency.
- Flags misaligned and out-of-range addresses.
- Enforces one recovery cycle after every completion so the arbiter can re-select before a new request is sampled.

Parameters:
- DATA_W, 64, width of the data buses and the address bus addr_m
- MEM_AW, 10, SRAM word-address width (depth 2^MEM_AW 64-bit words)
- RD_LAT, 2, SRAM read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..8

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr_m  in  64  byte address from arbiter
- dout_m  in  64  write data from arbiter
- din_m  out  64  read data to arbiter
- req_m  in  1  transaction request
- wr_m  in  1  1 = write, 0 = read
- rdy_m  out  1  one-cycle completion pulse
- err_m  out  1  error flag, valid only while rdy_m = 1
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata  out  64  SRAM write data
- mem_rdata  in  64  SRAM read data

Behaviour:
- Registered outputs: all outputs are registered.
- Reset values: rdy_m=0, err_m=0, din_m=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; FSM in IDLE; latency counter 0.
- Reset mid-operation: aborts any transaction with no rdy_m pulse; the SRAM strobe drops at the same edge.
- States: IDLE, ISSUE, WAIT, DONE, RECOVER.
- IDLE, req_m=0: stay in IDLE.
- IDLE, req_m=1, address check:
  - Latch addr_m, dout_m and wr_m at this edge.
  - Word address = addr_m[MEM_AW+2:3].
  - Misaligned: addr_m[2:0] != 0.
  - Out of range: any bit of addr_m[63:MEM_AW+3] set.
  - Either condition -> DONE with err_m=1 and no SRAM access.
  - Otherwise -> ISSUE.
- ISSUE: exactly one cycle.
  - Drives mem_en=1, mem_we=latched wr, mem_addr, mem_wdata.
  - Write -> DONE.
  - Read -> WAIT, counter loaded with RD_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, mem_rdata is captured into din_m at that edge -> DONE.
  - For RD_LAT=1, WAIT lasts one cycle.
  - mem_en=0 throughout.
- DONE: exactly one cycle; rdy_m=1, err_m per the check above.
  - Successful read: din_m holds the new data.
  - Error read: din_m=0.
  - Write or error write: din_m keeps its previous value.
  - Next state RECOVER.
- RECOVER: one cycle; req_m ignored; -> IDLE.
- Latency, from the IDLE cycle in which req_m=1 is sampled (T0):
  - Write: rdy_m in T2.
  - Read: rdy_m in T0+RD_LAT+2.
  - Error: rdy_m in T1.
  - Earliest next sample: two cycles after the DONE cycle.
- req_m deasserting after acceptance: no abort; the transaction completes normally.
- addr_m, dout_m, wr_m changing after acceptance: ignored, since the latched copies are used.
- din_m outside DONE: holds its last value; never X after reset.
- Address inputs: bits 63:0 only; no wrap-around.
- Illegal RD_LAT: values outside 1..8 are a configuration error; the RTL includes an elaboration-time check.

Test Plan:
- Reset, then write: addr_m=0x40, dout_m=0xDEADBEEF_00000001, wr_m=1 -> mem_en=1, mem_we=1, mem_addr=8 in T1; rdy_m=1, err_m=0 in T2; no sample in T3.
- Read back with RD_LAT=2: addr_m=0x40, wr_m=0, SRAM model returns stored word -> mem_en only in T1; rdy_m and din_m=0xDEADBEEF_00000001 in T4.
- Misaligned read addr_m=0x43, then out-of-range read addr_m=0x2000 (MEM_AW=10) -> each gives rdy_m=1, err_m=1, din_m=0 in T1 with mem_en never asserted.
- req_m held high continuously over 3 back-to-back writes -> accesses spaced 4 cycles apart (T0, T4, T8); exactly one rdy_m pulse per transaction.
- Reset asserted during WAIT of a read -> no rdy_m; din_m=0 and mem_en=0 after the reset edge; a fresh read after reset completes with correct latency.
- RD_LAT=1 and RD_LAT=8 builds: read rdy_m arrives at T3 and T10 respectively; req_m dropped after T0 does not cancel.

Source files
------------

// File: rtl/mem_seq.sv
// mem_seq: turns the arbiter's shared req/wr/rdy handshake into single-port synchronous SRAM
// cycles with a fixed read latency, address checking and a recovery cycle after each completion.
module mem_seq #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned MEM_AW = 10,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] addr_m,
   input  logic [DATA_W-1:0] dout_m,
   output logic [DATA_W-1:0] din_m,
   input  logic              req_m,
   input  logic              wr_m,
   output logic              rdy_m,
   output logic              err_m,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, RECOVER} state_t;

   if ((RD_LAT == 0) || (RD_LAT > 8)) begin : g_bad_rd_lat
      $error("mem_seq: RD_LAT must lie in 1..8");
   end

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_wr;
   logic               r_rdy;
   logic               r_err;
   logic [DATA_W-1:0]  r_din;
   logic               r_mem_en;
   logic               r_mem_we;
   logic [MEM_AW-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_mem_wdata;

   logic               w_misalign;
   logic               w_oor;
   logic               w_bad;

   // Byte address must be word aligned and fit inside the SRAM.
   assign w_misalign = |addr_m[2:0];
   assign w_oor      = |addr_m[DATA_W-1:MEM_AW+3];
   assign w_bad      = w_misalign | w_oor;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_wr        <= 1'b0;
         r_rdy       <= 1'b0;
         r_err       <= 1'b0;
         r_din       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_rdy    <= 1'b0;
         r_err    <= 1'b0;
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_m) begin
                  r_wr        <= wr_m;
                  r_mem_addr  <= addr_m[MEM_AW+2:3];
                  r_mem_wdata <= dout_m;
                  if (w_bad) begin
                     r_state <= DONE;
                     r_rdy   <= 1'b1;
                     r_err   <= 1'b1;
                     if (!wr_m) begin
                        r_din <= '0;
                     end
                  end else begin
                     r_state  <= ISSUE;
                     r_mem_en <= 1'b1;
                     r_mem_we <= wr_m;
                  end
               end
            end
            ISSUE: begin
               if (r_wr) begin
                  r_state <= DONE;
                  r_rdy   <= 1'b1;
               end else begin
                  r_state <= WAIT;
                  r_cnt   <= CNT_W'(RD_LAT - 1);
               end
            end
            // Counter reaching zero marks the cycle in which mem_rdata is valid.
            WAIT: begin
               if (r_cnt == '0) begin
                  r_din   <= mem_rdata;
                  r_state <= DONE;
                  r_rdy   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               r_state <= RECOVER;
            end
            RECOVER: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign din_m     = r_din;
   assign rdy_m     = r_rdy;
   assign err_m     = r_err;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
